// File: rtl/jtframe_pll_rstseq_pkg.sv
// Shared state encoding for the PLL reset sequencer and anything decoding its st port.
// The numeric values are visible on the debug port, so they are fixed explicitly.
package jtframe_pll_rstseq_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_PRST   = 3'd0,
    ST_WLOCK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3
  } state_t;

endpackage

// File: rtl/jtframe_pll_rstseq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL locked pin into the refclk domain.
module jtframe_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/jtframe_pll_rstseq.sv
// Frame PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry,
// qualifies lock over a settle window and only then releases the system reset.
module jtframe_pll_rstseq
  import jtframe_pll_rstseq_pkg::*;
#(
  parameter int RSTW   = 16,
  parameter int LOCKTO = 1000000,
  parameter int SETTLE = 4096,
  parameter int CW     = 20,
  parameter int TRYW   = 3
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            pll_locked,
  input  logic            relock,
  output logic            pll_rst,
  output logic            sys_rst,
  output logic            ready,
  output logic            fail,
  output logic [TRYW-1:0] retries,
  output logic [2:0]      st
);

  localparam longint TCAP = 64'd1 << CW;

  if (RSTW < 2) begin : g_rstw_chk
    $error("jtframe_pll_rstseq: RSTW must be at least 2");
  end
  if (RSTW > TCAP || LOCKTO > TCAP || SETTLE > TCAP) begin : g_cw_chk
    $error("jtframe_pll_rstseq: CW too narrow for RSTW/LOCKTO/SETTLE");
  end

  localparam logic [CW-1:0]   T_RST    = CW'(RSTW - 1);
  localparam logic [CW-1:0]   T_LOCK   = CW'(LOCKTO - 1);
  localparam logic [CW-1:0]   T_SETTLE = CW'(SETTLE - 1);
  localparam logic [TRYW-1:0] TRY_MAX  = {TRYW{1'b1}};

  function automatic logic [TRYW-1:0] sat_inc(input logic [TRYW-1:0] v);
    return (v == TRY_MAX) ? v : v + 1'b1;
  endfunction

  state_t          state, state_nx;
  logic [CW-1:0]   timer, timer_nx;
  logic [TRYW-1:0] retries_nx;
  logic            fail_nx;
  logic            pll_rst_nx, sys_rst_nx, ready_nx;
  logic            lk;

  jtframe_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pll_locked),
    .dout (lk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_PRST;
      timer   <= '0;
      retries <= '0;
      fail    <= 1'b0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      retries <= retries_nx;
      fail    <= fail_nx;
      pll_rst <= pll_rst_nx;
      sys_rst <= sys_rst_nx;
      ready   <= ready_nx;
    end
  end

  // Relock overrides every other event; a lock seen on the timeout cycle still wins over the timeout.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer + 1'b1;
    retries_nx = retries;
    fail_nx    = fail;
    if (relock && state != ST_PRST) begin
      state_nx = ST_PRST;
      timer_nx = '0;
    end else begin
      case (state)
        ST_PRST: begin
          if (timer == T_RST) begin
            state_nx = ST_WLOCK;
            timer_nx = '0;
          end
        end
        ST_WLOCK: begin
          if (lk) begin
            state_nx = ST_SETTLE;
            timer_nx = '0;
          end else if (timer == T_LOCK) begin
            state_nx   = ST_PRST;
            timer_nx   = '0;
            retries_nx = sat_inc(retries);
            fail_nx    = fail | (sat_inc(retries) == TRY_MAX);
          end
        end
        ST_SETTLE: begin
          if (!lk) begin
            state_nx = ST_WLOCK;
            timer_nx = '0;
          end else if (timer == T_SETTLE) begin
            state_nx = ST_RUN;
            timer_nx = '0;
          end
        end
        ST_RUN: begin
          timer_nx = '0;
          if (!lk) state_nx = ST_PRST;
        end
        default: begin
          state_nx = ST_PRST;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    pll_rst_nx = (state_nx == ST_PRST);
    sys_rst_nx = (state_nx != ST_RUN);
    ready_nx   = (state_nx == ST_RUN);
  end

  assign st = state;

endmodule
